trap_filter_param: RTL and testbench

- Second-generation trapezoidal shaping filter for ADC sample streams.
- Same K/L/M recursion as the fixed v14 shaper (d, p, r, s chain), with these additions:
  - sample-valid strobes instead of every-clock sampling;
  - run-time programmable K, L, M, with validation;
  - zero-history restart on reconfiguration;
  - saturating output with overflow flag;
  - fixed pipeline latency.
- Sits between the ADC capture block and the peak/amplitude logic.

---
 rtl/package_settings.sv | 5 +
 rtl/trap_pkg.sv | 25 ++
 rtl/trap_filter_param_if.sv | 28 ++
 rtl/trap_delay_line.sv | 55 +++++
 rtl/trap_filter_param.sv | 119 +++++++++++
 tb/tb_trap_filter_param.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/package_settings.sv
// Project-wide data widths shared by the capture and shaping blocks.
package package_settings;
  localparam int SIZE_ADC_DATA    = 12;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/trap_pkg.sv
// Shared constants, width helpers and config record for the trapezoidal shaper.
package trap_pkg;
  localparam int MAX_DEPTH = 64;
  localparam int M_W       = 8;
  localparam int SHIFT     = 4;
  localparam int K_DEF     = 2;
  localparam int L_DEF     = 4;
  localparam int M_DEF     = 0;
  localparam int CFG_W     = $clog2(MAX_DEPTH + 1);

  typedef struct packed {
    logic [CFG_W-1:0] k;
    logic [CFG_W-1:0] l;
    logic [M_W-1:0]   m;
  } trap_cfg_t;

  function automatic int d_width(input int data_w);
    return data_w + 2;
  endfunction

  // Sized so p, M*d, r and s never wrap for any legal K/L/M.
  function automatic int acc_width(input int data_w, input int max_depth, input int m_w);
    return data_w + 2 * $clog2(max_depth) + m_w + 3;
  endfunction
endpackage

// File: rtl/trap_filter_param_if.sv
// Sample, configuration and result signals of the trapezoidal shaper.
interface trap_filter_param_if #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 16,
  parameter int KW     = 7,
  parameter int M_W    = 8
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     cfg_load;
  logic [KW-1:0]            cfg_k;
  logic [KW-1:0]            cfg_l;
  logic [M_W-1:0]           cfg_m;
  logic                     cfg_err;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m,
    input  cfg_err, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, cfg_load, cfg_k, cfg_l, cfg_m,
    output cfg_err, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/trap_delay_line.sv
// Circular sample history with three zero-masked taps, read into registers on each write.
module trap_delay_line #(
  parameter int DATA_W    = 12,
  parameter int MAX_DEPTH = 64,
  parameter int AGE_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [AGE_W-1:0]         age_k,
  input  logic [AGE_W-1:0]         age_l,
  input  logic [AGE_W-1:0]         age_kl,
  output logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] x_k,
  output logic signed [DATA_W-1:0] x_l,
  output logic signed [DATA_W-1:0] x_kl
);
  localparam int DEPTH = MAX_DEPTH + 1;
  localparam int PW    = $clog2(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]            wp;
  logic [AGE_W-1:0]         fill;

  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] w, input logic [AGE_W-1:0] age);
    int a;
    a = int'(w) - int'(age);
    if (a < 0) a += DEPTH;
    return PW'(a);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp   <= '0;
      fill <= '0;
    end else begin
      if (wr_en) wp <= (wp == PW'(MAX_DEPTH)) ? '0 : wp + 1'b1;
      if (clear) fill <= '0;
      else if (wr_en && fill != AGE_W'(MAX_DEPTH)) fill <= fill + 1'b1;
    end
  end

  // Entries older than the fill count are stale history from before a restart.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= wr_data;
      x       <= wr_data;
      x_k     <= (age_k  <= fill) ? mem[tap_addr(wp, age_k)]  : '0;
      x_l     <= (age_l  <= fill) ? mem[tap_addr(wp, age_l)]  : '0;
      x_kl    <= (age_kl <= fill) ? mem[tap_addr(wp, age_kl)] : '0;
    end
  end
endmodule

// File: rtl/trap_filter_param.sv
// Programmable K/L/M trapezoidal shaper: 5-stage pipeline, restart on reconfig, saturating output.
module trap_filter_param #(
  parameter int DATA_W    = package_settings::SIZE_ADC_DATA,
  parameter int OUT_W     = package_settings::SIZE_FILTER_DATA,
  parameter int MAX_DEPTH = trap_pkg::MAX_DEPTH,
  parameter int M_W       = trap_pkg::M_W,
  parameter int SHIFT     = trap_pkg::SHIFT,
  parameter int K_DEF     = trap_pkg::K_DEF,
  parameter int L_DEF     = trap_pkg::L_DEF,
  parameter int M_DEF     = trap_pkg::M_DEF
) (
  input logic                clk,
  input logic                reset_n,
  trap_filter_param_if.slave bus
);
  import trap_pkg::*;

  localparam int KW    = $clog2(MAX_DEPTH + 1);
  localparam int AW    = KW + 1;
  localparam int D_W   = d_width(DATA_W);
  localparam int ACC_W = acc_width(DATA_W, MAX_DEPTH, M_W);
  localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

  logic [KW-1:0]            k_r, l_r;
  logic [M_W-1:0]           m_r;
  logic [AW-1:0]            sum_kl;
  logic                     cfg_ok, restart, accept;
  logic                     v1, v2, v3, v4;
  logic signed [DATA_W-1:0] x1, xk1, xl1, xkl1;
  logic signed [D_W-1:0]    d2;
  logic signed [ACC_W-1:0]  p, md3, r4, s, s_next, s_shr;

  assign sum_kl  = {1'b0, bus.cfg_k} + {1'b0, bus.cfg_l};
  assign cfg_ok  = (bus.cfg_k != '0) && (bus.cfg_k <= bus.cfg_l) && (sum_kl <= AW'(MAX_DEPTH));
  assign restart = bus.cfg_load && cfg_ok;
  // A config strobe always swallows a coincident sample.
  assign accept  = bus.in_valid && !bus.cfg_load;

  trap_delay_line #(
    .DATA_W    (DATA_W),
    .MAX_DEPTH (MAX_DEPTH),
    .AGE_W     (AW)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (restart),
    .wr_en   (accept),
    .wr_data (bus.in_data),
    .age_k   ({1'b0, k_r}),
    .age_l   ({1'b0, l_r}),
    .age_kl  ({1'b0, k_r} + {1'b0, l_r}),
    .x       (x1),
    .x_k     (xk1),
    .x_l     (xl1),
    .x_kl    (xkl1)
  );

  assign s_next = s + r4;
  assign s_shr  = s_next >>> SHIFT;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k_r           <= KW'(K_DEF);
      l_r           <= KW'(L_DEF);
      m_r           <= M_W'(M_DEF);
      v1            <= 1'b0;
      v2            <= 1'b0;
      v3            <= 1'b0;
      v4            <= 1'b0;
      d2            <= '0;
      p             <= '0;
      md3           <= '0;
      r4            <= '0;
      s             <= '0;
      bus.cfg_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      bus.cfg_err   <= bus.cfg_load && !cfg_ok;
      v1            <= accept;
      v2            <= v1;
      v3            <= v2;
      v4            <= v3;
      bus.out_valid <= v4;
      d2  <= D_W'(x1) - D_W'(xk1) - D_W'(xl1) + D_W'(xkl1);
      md3 <= ACC_W'(signed'({1'b0, m_r})) * ACC_W'(d2);
      r4  <= p + md3;
      if (v2) p <= p + ACC_W'(d2);
      if (v4) begin
        s <= s_next;
        if (s_shr > OUT_MAX) begin
          bus.out_data <= OUT_W'(OUT_MAX);
          bus.out_sat  <= 1'b1;
        end else if (s_shr < OUT_MIN) begin
          bus.out_data <= OUT_W'(OUT_MIN);
          bus.out_sat  <= 1'b1;
        end else begin
          bus.out_data <= OUT_W'(s_shr);
          bus.out_sat  <= 1'b0;
        end
      end
      // Restart wins over every pipeline update above, dropping in-flight samples.
      if (restart) begin
        k_r           <= bus.cfg_k;
        l_r           <= bus.cfg_l;
        m_r           <= bus.cfg_m;
        v1            <= 1'b0;
        v2            <= 1'b0;
        v3            <= 1'b0;
        v4            <= 1'b0;
        p             <= '0;
        s             <= '0;
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trap_filter_param.sv
// Directed bench for trap_filter_param: scoreboard of expected outputs keyed by due clock edge.
module tb_trap_filter_param;
  import package_settings::*;

  localparam int DW = SIZE_ADC_DATA;
  localparam int OW = SIZE_FILTER_DATA;
  localparam int MD = 64;
  localparam int KW = $clog2(MD + 1);
  localparam int MW = 8;
  localparam int SH = 0;
  localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint OMIN = -OMAX - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  trap_filter_param_if #(.DATA_W(DW), .OUT_W(OW), .KW(KW), .M_W(MW)) bus ();

  trap_filter_param #(
    .DATA_W(DW), .OUT_W(OW), .MAX_DEPTH(MD), .M_W(MW), .SHIFT(SH),
    .K_DEF(2), .L_DEF(4), .M_DEF(0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int     due;
    longint val;
    bit     sat;
  } exp_t;

  exp_t   sb[$];
  longint hist[$];
  int     edge_cnt = 0;
  int     checks = 0;
  int     errors = 0;
  int     cfg_err_due = -1;
  int     mk, ml, mm;
  longint mp, ms;
  longint plan1[8] = '{100, 300, 500, 700, 800, 800, 800, 800};
  longint plan2[7] = '{128, 128, 128, 64, 0, 0, 0};

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @edge %0d: observed=%0d expected=%0d", tag, edge_cnt, obs, exp);
    end
  endtask

  function automatic longint htap(input int j);
    if (j > 0 && j <= hist.size()) return hist[hist.size() - j];
    return 0;
  endfunction

  task automatic model_restart();
    hist.delete();
    mp = 0;
    ms = 0;
  endtask

  task automatic model_step(input longint x, output longint y, output bit sat);
    longint d, v;
    d = x - htap(mk) - htap(ml) + htap(mk + ml);
    hist.push_back(x);
    mp += d;
    ms += mp + longint'(mm) * d;
    v = ms >>> SH;
    if (v > OMAX) begin y = OMAX; sat = 1'b1; end
    else if (v < OMIN) begin y = OMIN; sat = 1'b1; end
    else begin y = v; sat = 1'b0; end
  endtask

  task automatic flush_from(input int e);
    while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    edge_cnt++;
    #1;
    chk("cfg_err", bus.cfg_err, (edge_cnt == cfg_err_due) ? 1 : 0);
    if (sb.size() > 0 && sb[0].due == edge_cnt) begin
      e = sb.pop_front();
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, e.val);
      chk("out_sat", bus.out_sat, e.sat);
    end else begin
      chk("out_valid_idle", bus.out_valid, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input longint x, input bit ovr = 1'b0, input longint cval = 0, input bit csat = 1'b0);
    exp_t   e;
    longint y;
    bit     s;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(x);
    model_step(x, y, s);
    e.due = edge_cnt + 5;
    e.val = ovr ? cval : y;
    e.sat = ovr ? csat : s;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg(input int k, input int l, input int m, input bit with_sample);
    bus.cfg_load = 1'b1;
    bus.cfg_k    = KW'(k);
    bus.cfg_l    = KW'(l);
    bus.cfg_m    = MW'(m);
    bus.in_valid = with_sample;
    bus.in_data  = DW'(777);
    if (k >= 1 && k <= l && k + l <= MD) begin
      mk = k; ml = l; mm = m;
      model_restart();
      flush_from(edge_cnt + 1);
    end else begin
      cfg_err_due = edge_cnt + 1;
    end
    tick();
    bus.cfg_load = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(500);
    flush_from(edge_cnt + 1);
    cfg_err_due = -1;
    mk = 2; ml = 4; mm = 0;
    model_restart();
    tick();
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.cfg_load = 1'b0;
    bus.cfg_k    = '0;
    bus.cfg_l    = '0;
    bus.cfg_m    = '0;
    mk = 2; ml = 4; mm = 0;
    model_restart();
    idle(1);
    do_reset();

    // Step with default K=2, L=4, M=0.
    repeat (3) sample(0, 1'b1, 0);
    for (int i = 0; i < 8; i++) sample(100, 1'b1, plan1[i]);
    idle(6);

    // Impulse.
    cfg(2, 4, 0, 1'b0);
    sample(64, 1'b1, 64);
    for (int i = 0; i < 7; i++) sample(0, 1'b1, plan2[i]);
    idle(6);

    // Gapped step: same values, gaps preserved.
    cfg(2, 4, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample(100, 1'b1, plan1[i]);
      idle(2);
    end
    idle(4);

    // Saturation both ways with K=L=16.
    cfg(16, 16, 0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i >= 32) sample(2047, 1'b1, 32767, 1'b1);
      else sample(2047);
    end
    idle(6);
    cfg(16, 16, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i >= 32) sample(-2048, 1'b1, -32768, 1'b1);
      else sample(-2048);
    end
    idle(6);

    // Config validation.
    cfg(2, 4, 0, 1'b0);
    cfg(5, 3, 0, 1'b1);
    for (int i = 0; i < 8; i++) sample(100, 1'b1, plan1[i]);
    idle(6);
    cfg(0, 5, 0, 1'b0);
    idle(1);
    cfg(1, MD, 0, 1'b0);
    idle(1);
    cfg(32, 32, 0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      if (i >= 66) sample(30, 1'b1, 30 * 32 * 32);
      else sample(30);
    end
    idle(6);

    // Restart during a plateau drops in-flight samples.
    cfg(2, 4, 0, 1'b0);
    repeat (10) sample(100);
    cfg(2, 4, 0, 1'b1);
    for (int i = 0; i < 8; i++) sample(100, 1'b1, plan1[i]);
    idle(6);

    // Nonzero M with random data, then reset mid-stream.
    cfg(3, 5, 2, 1'b0);
    repeat (20) sample(longint'($urandom_range(1000)) - 500);
    do_reset();
    for (int i = 0; i < 8; i++) sample(100, 1'b1, plan1[i]);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
